// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers used by the
// key schedule and the cipher round controller.
package aes_pkg;

   localparam int          NR        = 10;
   localparam int          KW        = 128;
   localparam logic [7:0]  RCON_INIT = 8'h01;
   localparam logic [7:0]  RCON_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } ks_state_t;

   // multiply by x in GF(2^8), reducing by the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   // general GF(2^8) multiply by shift-and-add
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Control/read bus between the key schedule and its user.
interface key_schedule_ctrl_if #(
   parameter int KW = 128
);
   logic          start;
   logic [KW-1:0] key_in;
   logic [3:0]    rd_addr;
   logic [KW-1:0] rk_out;
   logic          busy;
   logic          done;
   logic          keys_valid;

   modport master (
      output start, key_in, rd_addr,
      input  rk_out, busy, done, keys_valid
   );

   modport slave (
      input  start, key_in, rd_addr,
      output rk_out, busy, done, keys_valid
   );
endinterface

// File: rtl/key_schedule_ctrl_subkey.sv
// One AES-128 key-expansion round: next round key from the previous one
// and the round constant. Purely combinational.
module SubKey
   import aes_pkg::*;
(
   input  logic [127:0] keyin,
   input  logic [7:0]   rcon,
   output logic [127:0] keyout
);

   // S-box computed as multiplicative inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] inv;
      p   = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
   endfunction

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t;
   logic [31:0] n0, n1, n2, n3;

   // RotWord + SubWord + rcon on the last word, then the XOR chain
   always_comb begin
      w0 = keyin[127:96];
      w1 = keyin[95:64];
      w2 = keyin[63:32];
      w3 = keyin[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      keyout = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands one round key per cycle into an
// NR+1 entry store and serves registered reads from it.
module key_schedule_ctrl
   import aes_pkg::*;
#(
   parameter int NR = aes_pkg::NR,
   parameter int KW = aes_pkg::KW
)(
   input  logic               clk,
   input  logic               rst,
   key_schedule_ctrl_if.slave ks
);

   localparam logic [3:0] LAST = 4'(NR);

   ks_state_t     state, state_nxt;
   logic [3:0]    cnt;
   logic [7:0]    rcon;
   logic          done_r;
   logic [KW-1:0] rk_q;
   logic [KW-1:0] slot [0:NR];
   logic [KW-1:0] prev_key;
   logic [KW-1:0] new_key;
   logic          accept;

   // start is only honoured when no expansion is running
   always_comb accept = ks.start && (state == ST_IDLE || state == ST_DONE);

   // previous round key feeding the single SubKey instance
   always_comb begin
      prev_key = '0;
      if (cnt != 4'd0 && cnt <= LAST) prev_key = slot[cnt - 4'd1];
   end

   SubKey u_subkey (
      .keyin  (prev_key),
      .keyout (new_key),
      .rcon   (rcon)
   );

   // state register, round counter, rcon and the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         rcon   <= RCON_INIT;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= (state == ST_EXPAND) && (cnt == LAST);
         if (accept) begin
            cnt  <= 4'd1;
            rcon <= RCON_INIT;
         end else if (state == ST_EXPAND && cnt != LAST) begin
            cnt  <= cnt + 4'd1;
            rcon <= xtime(rcon);
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (ks.start)     state_nxt = ST_EXPAND;
         ST_EXPAND: if (cnt == LAST)  state_nxt = ST_DONE;
         ST_DONE:   if (ks.start)     state_nxt = ST_EXPAND;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   // round-key store: key at accept, one expanded key per EXPAND cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept)
            slot[0] <= ks.key_in;
         else if (state == ST_EXPAND && cnt != 4'd0 && cnt <= LAST)
            slot[cnt] <= new_key;
      end
   end

   // registered read port; sees the pre-write value on a same-cycle hit
   always_ff @(posedge clk) begin
      if (rst)
         rk_q <= '0;
      else if (ks.rd_addr > LAST)
         rk_q <= '0;
      else
         rk_q <= slot[ks.rd_addr];
   end

   // outputs
   always_comb begin
      ks.busy       = (state == ST_EXPAND);
      ks.keys_valid = (state == ST_DONE);
      ks.done       = done_r;
      ks.rk_out     = rk_q;
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: reads are scored through an
// expected-value queue drained by an independent monitor.
module tb_key_schedule_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_schedule_ctrl_if #(.KW(128)) ksif();

   key_schedule_ctrl #(.NR(10), .KW(128)) dut (
      .clk (clk),
      .rst (rst),
      .ks  (ksif)
   );

   localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] K1_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
   localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]   addr;
      logic [127:0] exp;
   } rd_exp_t;

   rd_exp_t sb[$];
   logic    rd_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: a read issued at an edge is answered on rk_out just after it
   initial begin : monitor
      logic    en;
      rd_exp_t e;
      forever begin
         @(posedge clk);
         en = rd_en;
         #1;
         if (en) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow: got read with no expectation");
            end else begin
               e = sb.pop_front();
               check($sformatf("rk[%0d]", e.addr), ksif.rk_out, e.exp);
            end
         end
      end
   end

   task automatic rd(input logic [3:0] a, input logic [127:0] e);
      rd_exp_t x;
      @(negedge clk);
      ksif.rd_addr = a;
      rd_en        = 1'b1;
      x.addr = a;
      x.exp  = e;
      sb.push_back(x);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   // one expansion; optional ignored mid-run start and optional reset abort
   task automatic run(input logic [127:0] key, input int mid_k, input int rst_k, input string tag);
      int   done_cyc;
      int   busy_n;
      logic kv_done, kv9, done11, busy_r, kv_r;
      done_cyc = -1;
      busy_n   = 0;
      kv_done  = 1'b0;
      kv9      = 1'b0;
      done11   = 1'b0;
      busy_r   = 1'b1;
      kv_r     = 1'b1;
      @(negedge clk);
      ksif.key_in = key;
      ksif.start  = 1'b1;
      @(posedge clk);
      #1;
      ksif.start = 1'b0;
      check({tag, "_busy_at_accept"}, ksif.busy, 1);
      check({tag, "_kv_at_accept"}, ksif.keys_valid, 0);
      if (ksif.busy) busy_n++;
      for (int k = 1; k <= 20; k++) begin
         if (k == mid_k) begin
            ksif.start  = 1'b1;
            ksif.key_in = '0;
         end
         rst = (k == rst_k);
         @(posedge clk);
         #1;
         ksif.start = 1'b0;
         if (ksif.busy) busy_n++;
         if (ksif.done && done_cyc < 0) begin
            done_cyc = k;
            kv_done  = ksif.keys_valid;
         end
         if (k == 9)  kv9    = ksif.keys_valid;
         if (k == 11) done11 = ksif.done;
         if (k == rst_k) begin
            busy_r = ksif.busy;
            kv_r   = ksif.keys_valid;
         end
      end
      rst = 1'b0;
      if (rst_k > 0) begin
         check({tag, "_busy_after_rst"}, busy_r, 0);
         check({tag, "_kv_after_rst"}, kv_r, 0);
         check({tag, "_no_done"}, done_cyc, -1);
      end else begin
         check({tag, "_done_cycle"}, done_cyc, 10);
         check({tag, "_busy_cycles"}, busy_n, 10);
         check({tag, "_kv_with_done"}, kv_done, 1);
         check({tag, "_kv_before_done"}, kv9, 0);
         check({tag, "_done_single"}, done11, 0);
      end
   endtask

   initial begin
      rst          = 1'b1;
      ksif.start   = 1'b0;
      ksif.key_in  = '0;
      ksif.rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", ksif.busy, 0);
      check("rst_done", ksif.done, 0);
      check("rst_kv", ksif.keys_valid, 0);
      check("rst_rk_out", ksif.rk_out, 0);
      @(negedge clk);
      rst = 1'b0;

      run(K1, 0, 0, "run1");
      rd(4'd0, K1);
      rd(4'd1, K1_R1);
      rd(4'd2, K1_R2);
      rd(4'd3, K1_R3);
      rd(4'd10, K1_R10);

      run(K1, 4, 0, "mid_start");
      rd(4'd1, K1_R1);
      rd(4'd10, K1_R10);

      for (int a = 11; a <= 15; a++) rd(4'(a), '0);

      run(K1, 0, 5, "abort");
      run(K1, 0, 0, "after_abort");
      rd(4'd10, K1_R10);

      run('0, 0, 0, "zero_key");
      rd(4'd10, K0_R10);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES-128 expansion rounds.
REQ-002 SHALL have parameter KW, default 128, meaning the key and round-key width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to expand key_in; sampled only when the FSM is in IDLE or DONE.
REQ-006 SHALL have port key_in, input, KW bits: cipher key, captured in the cycle start is accepted.
REQ-007 SHALL have port rd_addr, input, 4 bits: round-key index, 0..NR.
REQ-008 SHALL have port rk_out, output, KW bits: registered round key selected by rd_addr.
REQ-009 SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when round key NR is stored.
REQ-011 SHALL have port keys_valid, output, 1 bit: high while the store holds a complete schedule.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND and DONE.
REQ-013 SHALL move IDLE->EXPAND on start, storing key_in as round key 0, setting the round counter to 1 and rcon to 8'h01.
REQ-014 In EXPAND, SHALL compute one round per cycle: the SubKey output from the previous round key and the current rcon is written to slot[counter].
REQ-015 SHALL advance rcon per round by GF(2^8) xtime (left shift, XOR 8'h1B on carry-out), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-016 SHALL move EXPAND->DONE after writing slot NR, pulsing done in that transition cycle.
REQ-017 SHALL write round key 0 at the start-accept edge and round key NR exactly NR cycles later, so done is high NR cycles after the start-accept edge.
REQ-018 SHALL drive busy high in EXPAND and low otherwise.
REQ-019 SHALL set keys_valid in DONE; start while in DONE clears keys_valid and re-enters EXPAND with the new key_in.
REQ-020 SHALL ignore start while in EXPAND, leaving the key and the sequence unaffected.
REQ-021 SHALL register rk_out with one-cycle read latency: rk_out(t+1) = slot[rd_addr(t)].
REQ-022 SHALL drive rk_out to zero when rd_addr > NR.
REQ-023 SHALL let reads proceed in any state; slots not yet written in the current expansion return stale data, and keys_valid qualifies the result.
REQ-024 SHALL return the old value when a read and a write hit the same slot in the same cycle (read-before-write).

Reset
REQ-025 On rst SHALL force FSM=IDLE, counter=0, rcon=8'h01, busy=0, done=0, keys_valid=0, rk_out=0.
REQ-026 Slot contents need no reset; rst SHALL take priority over start in the same cycle.
REQ-027 rst during EXPAND SHALL abort the expansion, and no done pulse SHALL follow.

Structure
REQ-028 SHALL place NR, KW, RCON_INIT (8'h01) and RCON_POLY (8'h1B) in shared package aes_pkg, which the cipher round controller also uses.
REQ-029 SHALL instantiate exactly one existing SubKey sub-module (ports keyin, keyout, rcon), reused every round; no other sub-modules.
REQ-030 SHALL implement the store as 11 x 128-bit registers with a single write port and a single read port.

Verification
REQ-031 The bench SHALL cover start with key_in=2b7e151628aed2a6abf7158809cf4f3c: after done, rd_addr=1 -> a0fafe1788542cb123a339392a6c7605; rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 With the same key, the bench SHALL check rd_addr=2 -> f2c295f27a96b9435935807a7359f67f and rd_addr=3 -> 3d80477d4716fe3e1e237e446d7a883b (rcon 04 round).
REQ-033 The bench SHALL check the timing: done exactly 10 cycles after the start-accept edge; busy high for 10 cycles; keys_valid rising together with done.
REQ-034 The bench SHALL pulse start again mid-EXPAND with key_in=0 and check that the schedule still matches REQ-031 and the done timing is unchanged.
REQ-035 The bench SHALL assert rst at round 5, then check busy=0, keys_valid=0 and no done pulse; a following start completes normally.
REQ-036 The bench SHALL check that rd_addr=11..15 gives rk_out=0, and that a restart from DONE with key_in=0 gives rd_addr=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
